// File: rtl/fpu_add_result_buffer_if.sv
// Signal bundle between the FP32 adder result buffer, its operand source, the adder and
// the result consumer. The buffer takes the slave side.
interface fpu_add_result_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             issue_vld;
    logic             issue_rdy;
    logic             adder_arg_vld;
    logic [WIDTH-1:0] res_in;
    logic [1:0]       res_state_in;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_flags;
    logic [OCC_W-1:0] occupancy;
    logic             err_ovf;

    modport slave (
        input  issue_vld, res_in, res_state_in, out_rdy,
        output issue_rdy, adder_arg_vld, out_vld, out_data, out_flags, occupancy, err_ovf
    );

    modport master (
        output issue_vld, res_in, res_state_in, out_rdy,
        input  issue_rdy, adder_arg_vld, out_vld, out_data, out_flags, occupancy, err_ovf
    );
endinterface

// File: rtl/fpu_add_result_buffer.sv
// Credit-controlled issue, in-flight tracking and classified result FIFO for a
// fixed-latency FP32 adder that has neither stall nor valid-out.
module fpu_add_result_buffer #(
    parameter int LATENCY = 7,
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_add_result_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic denorm;
    } class_flags_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        class_flags_t     flags;
    } entry_t;

    logic [LATENCY-1:0] vsr;
    logic [OCC_W-1:0]   inflight;
    logic [OCC_W-1:0]   occ;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               err_ovf_q;
    entry_t             mem [DEPTH];

    entry_t wr_entry;
    logic   credit_ok;
    logic   issue;
    logic   cap;
    logic   full;
    logic   push;
    logic   pop;
    logic   out_vld;

    // The adder drops specials, so a special-operand result is replaced by the canonical qNaN.
    function automatic entry_t classify(input logic [WIDTH-1:0] res, input logic [1:0] state);
        entry_t     e;
        logic [7:0] exp_f;
        logic [22:0] man;
        exp_f   = res[30:23];
        man     = res[22:0];
        e.data  = res;
        e.flags = '0;
        if (state == 2'b10) begin
            e.data      = QNAN;
            e.flags.nan = 1'b1;
        end else if (exp_f == 8'hFF) begin
            e.flags.nan = (man != '0);
            e.flags.inf = (man == '0);
        end else if (exp_f == 8'h00) begin
            e.flags.zero   = (man == '0);
            e.flags.denorm = (man != '0);
        end
        return e;
    endfunction

    // Every op in the adder already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_ok = rst && (({1'b0, inflight} + {1'b0, occ}) < (OCC_W + 1)'(DEPTH));
    assign issue     = bus.issue_vld && credit_ok;
    assign cap       = vsr[LATENCY-1];
    assign full      = (occ == OCC_W'(DEPTH));
    assign push      = cap && !full;
    assign out_vld   = (occ != '0);
    assign pop       = out_vld && bus.out_rdy;
    assign wr_entry  = classify(bus.res_in, bus.res_state_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsr       <= '0;
            inflight  <= '0;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            vsr <= {vsr[LATENCY-2:0], issue};

            unique case ({issue, cap})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase

            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase

            if (push)        wr_ptr    <= wr_ptr + 1'b1;
            if (pop)         rd_ptr    <= rd_ptr + 1'b1;
            if (cap && full) err_ovf_q <= 1'b1;
        end
    end

    // NOTE: storage has no reset; an entry is only read after it has been written, and
    // leaving it out of the reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign bus.issue_rdy     = credit_ok;
    assign bus.adder_arg_vld = issue;
    assign bus.out_vld       = out_vld;
    assign bus.out_data      = out_vld ? mem[rd_ptr].data : '0;
    assign bus.out_flags     = out_vld ? mem[rd_ptr].flags : '0;
    assign bus.occupancy     = occ;
    assign bus.err_ovf       = err_ovf_q;
endmodule

// File: tb/tb_fpu_add_result_buffer.sv
// Directed bench for fpu_add_result_buffer: emulates a fixed-latency adder and checks every
// cycle against a queue-based model, plus literal spot checks.
module tb_fpu_add_result_buffer;
    localparam int LATENCY = 7;
    localparam int DEPTH   = 4;
    localparam int WIDTH   = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpu_add_result_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fpu_add_result_buffer #(.LATENCY(LATENCY), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
    } result_t;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [1:0]  state;
    } op_t;

    // Model state: ops the adder is working on, and what the consumer must see in order.
    result_t     exp_q[$];
    op_t         pending[$];
    logic [31:0] adder_res[int];
    logic [1:0]  adder_state[int];
    logic        exp_ovf = 1'b0;
    int          cyc = 0;
    logic [31:0] next_res = 32'h0;
    logic [1:0]  next_state = 2'b11;

    function automatic result_t expect_of(input logic [31:0] r, input logic [1:0] s);
        result_t x;
        int      e;
        int      m;
        e       = int'(r[30:23]);
        m       = int'(r[22:0]);
        x.data  = r;
        x.flags = 4'b0000;
        if (s == 2'b10) begin
            x.data  = 32'h7FC0_0000;
            x.flags = 4'b1000;
        end else if (e == 255) begin
            x.flags = (m != 0) ? 4'b1000 : 4'b0100;
        end else if (e == 0) begin
            x.flags = (m != 0) ? 4'b0001 : 4'b0010;
        end
        return x;
    endfunction

    function automatic bit model_rdy();
        return (pending.size() + exp_q.size()) < DEPTH;
    endfunction

    // Model update at each rising edge, from the inputs of the cycle that just ended.
    bit      m_accept;
    bit      m_full;
    result_t m_popped;
    op_t     m_op;
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            pending.delete();
            exp_ovf = 1'b0;
        end else begin
            m_accept = bus.issue_vld && model_rdy();
            m_full   = (exp_q.size() == DEPTH);
            if (bus.out_rdy && exp_q.size() != 0) m_popped = exp_q.pop_front();
            if (pending.size() != 0 && pending[0].due == cyc) begin
                m_op = pending.pop_front();
                if (m_full) exp_ovf = 1'b1;
                else        exp_q.push_back(expect_of(m_op.res, m_op.state));
            end
            if (m_accept) begin
                m_op.due   = cyc + LATENCY;
                m_op.res   = next_res;
                m_op.state = next_state;
                pending.push_back(m_op);
                adder_res[m_op.due]   = next_res;
                adder_state[m_op.due] = next_state;
            end
        end
        cyc++;
    end

    // Adder emulation: results appear exactly LATENCY cycles after issue, even across a reset.
    initial begin
        bus.res_in       = 32'h0;
        bus.res_state_in = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (adder_res.exists(cyc)) begin
                bus.res_in       = adder_res[cyc];
                bus.res_state_in = adder_state[cyc];
            end else begin
                bus.res_in       = 32'hDEAD_BEEF;
                bus.res_state_in = 2'b00;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit c_rdy;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("rst_out_vld", 32'(bus.out_vld), 32'd0);
            check("rst_issue_rdy", 32'(bus.issue_rdy), 32'd0);
            check("rst_occupancy", 32'(bus.occupancy), 32'd0);
            check("rst_out_data", bus.out_data, 32'd0);
            check("rst_out_flags", 32'(bus.out_flags), 32'd0);
            check("rst_err_ovf", 32'(bus.err_ovf), 32'd0);
        end else begin
            c_rdy = model_rdy();
            check("issue_rdy", 32'(bus.issue_rdy), 32'(c_rdy));
            check("adder_arg_vld", 32'(bus.adder_arg_vld), 32'(bus.issue_vld && c_rdy));
            check("out_vld", 32'(bus.out_vld), 32'(exp_q.size() != 0));
            check("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
            check("err_ovf", 32'(bus.err_ovf), 32'(exp_ovf));
            if (exp_q.size() != 0) begin
                check("out_data", bus.out_data, exp_q[0].data);
                check("out_flags", 32'(bus.out_flags), 32'(exp_q[0].flags));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t4_res   [4] = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0001, 32'h7F80_0000};
    logic [1:0]  t4_state [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    logic [31:0] t4_data  [4] = '{32'h7FC0_0000, 32'h0000_0000, 32'h0000_0001, 32'h7F80_0000};
    logic [3:0]  t4_flags [4] = '{4'b1000, 4'b0010, 4'b0001, 4'b0100};
    logic [31:0] t5_res   [8] = '{32'h4000_0000, 32'h7FC0_0001, 32'h8000_0000, 32'hFF80_0000,
                                  32'h0040_0000, 32'hC0A0_0000, 32'h4120_0000, 32'h3F00_0000};

    initial begin
        int acc;
        int outs;
        bus.issue_vld = 1'b0;
        bus.out_rdy   = 1'b0;
        repeat (3) next_cycle();

        // 1: single op, 1.0 + 2.0
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("t1_rdy_after_release", 32'(bus.issue_rdy), 32'd1);
        next_cycle();
        bus.issue_vld = 1'b1;
        next_res      = 32'h4040_0000;
        next_state    = 2'b11;
        @(negedge clk);
        check("t1_arg_vld", 32'(bus.adder_arg_vld), 32'd1);
        next_cycle();
        bus.issue_vld = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        check("t1_not_yet", 32'(bus.out_vld), 32'd0);
        next_cycle();
        @(negedge clk);
        check("t1_out_vld", 32'(bus.out_vld), 32'd1);
        check("t1_out_data", bus.out_data, 32'h4040_0000);
        check("t1_out_flags", 32'(bus.out_flags), 32'd0);
        next_cycle();
        bus.out_rdy = 1'b1;
        next_cycle();
        bus.out_rdy = 1'b0;

        // 2: issue held, consumer stalled
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            bus.issue_vld = 1'b1;
            next_res      = 32'h3F80_0000 + 32'(i);
            @(negedge clk);
            if (bus.adder_arg_vld) acc++;
        end
        check("t2_accepted", 32'(acc), 32'd4);
        check("t2_issue_rdy", 32'(bus.issue_rdy), 32'd0);
        check("t2_occupancy", 32'(bus.occupancy), 32'd4);
        check("t2_err_ovf", 32'(bus.err_ovf), 32'd0);

        // 3: one pop from full; credit returns a cycle later
        next_cycle();
        bus.out_rdy = 1'b1;
        next_res    = 32'h4120_0000;
        @(negedge clk);
        check("t3_rdy_pop_cycle", 32'(bus.issue_rdy), 32'd0);
        next_cycle();
        bus.out_rdy = 1'b0;
        @(negedge clk);
        check("t3_rdy_next", 32'(bus.issue_rdy), 32'd1);
        check("t3_accept", 32'(bus.adder_arg_vld), 32'd1);
        next_cycle();
        bus.issue_vld = 1'b0;
        @(negedge clk);
        check("t3_rdy_again", 32'(bus.issue_rdy), 32'd0);
        check("t3_occupancy", 32'(bus.occupancy), 32'd3);
        repeat (9) next_cycle();
        @(negedge clk);
        check("t3_refilled", 32'(bus.occupancy), 32'd4);
        next_cycle();
        bus.out_rdy = 1'b1;
        repeat (4) next_cycle();
        bus.out_rdy = 1'b0;
        @(negedge clk);
        check("t3_drained", 32'(bus.out_vld), 32'd0);

        // 4: classification
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.issue_vld = 1'b1;
            next_res      = t4_res[i];
            next_state    = t4_state[i];
        end
        next_cycle();
        bus.issue_vld = 1'b0;
        next_state    = 2'b11;
        repeat (8) next_cycle();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.out_rdy = 1'b1;
            @(negedge clk);
            check($sformatf("t4_data_%0d", i), bus.out_data, t4_data[i]);
            check($sformatf("t4_flags_%0d", i), 32'(bus.out_flags), 32'(t4_flags[i]));
        end
        next_cycle();
        bus.out_rdy = 1'b0;

        // 5: streaming with the consumer always ready
        acc  = 0;
        outs = 0;
        for (int i = 0; i < 24; i++) begin
            next_cycle();
            bus.out_rdy   = 1'b1;
            bus.issue_vld = 1'b1;
            next_res      = t5_res[i % 8] + 32'(i / 8);
            @(negedge clk);
            if (bus.adder_arg_vld) acc++;
            if (bus.out_vld) outs++;
            check("t5_occ_le1", 32'(bus.occupancy <= 1), 32'd1);
        end
        next_cycle();
        bus.issue_vld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_vld) outs++;
            next_cycle();
        end
        check("t5_out_count", 32'(outs), 32'(acc));
        check("t5_min_accepts", 32'(acc >= 8), 32'd1);
        bus.out_rdy = 1'b0;

        // 6: reset with ops queued and in flight
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            bus.issue_vld = 1'b1;
            next_res      = 32'h4100_0000 + 32'(i);
        end
        next_cycle();
        bus.issue_vld = 1'b0;
        repeat (8) next_cycle();
        @(negedge clk);
        check("t6_queued", 32'(bus.occupancy), 32'd2);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            bus.issue_vld = 1'b1;
            next_res      = 32'h4200_0000 + 32'(i);
        end
        next_cycle();
        bus.issue_vld = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_out_vld_in_rst", 32'(bus.out_vld), 32'd0);
        check("t6_occ_in_rst", 32'(bus.occupancy), 32'd0);
        check("t6_rdy_in_rst", 32'(bus.issue_rdy), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rdy_after_release", 32'(bus.issue_rdy), 32'd1);
        outs = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            @(negedge clk);
            if (bus.out_vld) outs++;
        end
        check("t6_no_stale_outputs", 32'(outs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
